// File: rtl/hazard_stall_unit.sv
// Hazard and stall controller for the five-stage core: load-use stalls,
// multi-cycle mult/matr occupancy of ID, and taken-branch flushes of IF/ID.
module hazard_stall_unit #(
  parameter int MULT_LAT = 3,
  parameter int MATR_LAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] id_opcode,
  input  logic [6:0] id_funct7,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rd,
  input  logic       ex_BranchTaken,
  output logic       CtrlSrc,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       busy
);

  localparam int MAX_LAT = (MULT_LAT > MATR_LAT) ? MULT_LAT : MATR_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULT   = 7'b0000001;
  localparam logic [6:0] F7_MATR   = 7'b0000011;

  typedef enum logic {
    IDLE,
    MULTI
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat_r;

  logic          uses_rs1;
  logic          uses_rs2;
  logic          is_mult;
  logic          is_matr;
  logic          load_use;
  logic [CW-1:0] op_lat;
  logic          enter_multi;
  logic          count_more;
  logic          stall;

  // Decode of the instruction sitting in IF/ID; unknown opcodes read no registers.
  always_comb begin
    uses_rs1 = (id_opcode == OP_RTYPE) || (id_opcode == OP_ADDI) ||
               (id_opcode == OP_LOAD)  || (id_opcode == OP_STORE) ||
               (id_opcode == OP_BRANCH);
    uses_rs2 = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) ||
               (id_opcode == OP_BRANCH);
    is_mult  = (id_opcode == OP_RTYPE) && (id_funct7 == F7_MULT);
    is_matr  = (id_opcode == OP_RTYPE) && (id_funct7 == F7_MATR);
    load_use = ex_MemRead && (ex_rd != 5'd0) &&
               ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));
    op_lat   = is_mult ? CW'(MULT_LAT) : (is_matr ? CW'(MATR_LAT) : '0);
    // A single-cycle multi-op behaves like any other instruction.
    enter_multi = (is_mult || is_matr) && (op_lat >= CW'(2));
    count_more  = (cnt < (lat_r - CW'(1)));
  end

  // Mealy decision: reset, then flush, then an in-flight multi count, then IDLE hazards.
  always_comb begin
    stall = 1'b0;
    if (!rst && !ex_BranchTaken) begin
      if (state == MULTI) begin
        stall = count_more;
      end else begin
        stall = load_use || enter_multi;
      end
    end
  end

  always_comb begin
    CtrlSrc   = 1'b0;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    if (rst || stall) begin
      CtrlSrc   = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (ex_BranchTaken) begin
      CtrlSrc   = 1'b1;
      IFIDFlush = 1'b1;
    end
  end

  assign busy = (state == MULTI) && !rst;

  // Once in MULTI only lat_r governs; the ID opcode and load-use are ignored until release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lat_r <= '0;
    end else if (ex_BranchTaken) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!load_use && enter_multi) begin
            state <= MULTI;
            cnt   <= CW'(1);
            lat_r <= op_lat;
          end
        end
        MULTI: begin
          if (count_more) begin
            cnt <= cnt + CW'(1);
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed hazard scenarios plus a
// randomized run against a countdown-based behavioural model.
module tb_hazard_stall_unit;

  localparam int MULT_LAT = 3;
  localparam int MATR_LAT = 8;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Expected {CtrlSrc, PCWrite, IFIDWrite, IFIDFlush, busy}
  localparam logic [4:0] E_NORM       = 5'b01100;
  localparam logic [4:0] E_STALL      = 5'b10000;
  localparam logic [4:0] E_STALL_BUSY = 5'b10001;
  localparam logic [4:0] E_REL_BUSY   = 5'b01101;
  localparam logic [4:0] E_FLUSH      = 5'b11110;
  localparam logic [4:0] E_FLUSH_BUSY = 5'b11111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] id_opcode;
  logic [6:0] id_funct7;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_MemRead;
  logic [4:0] ex_rd;
  logic       ex_BranchTaken;
  logic       CtrlSrc;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IFIDFlush;
  logic       busy;
  logic [4:0] obs;

  int checks = 0;
  int errors = 0;

  hazard_stall_unit #(.MULT_LAT(MULT_LAT), .MATR_LAT(MATR_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .ex_BranchTaken(ex_BranchTaken),
    .CtrlSrc(CtrlSrc), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .busy(busy)
  );

  assign obs = {CtrlSrc, PCWrite, IFIDWrite, IFIDFlush, busy};

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [6:0] op, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic mr, input logic [4:0] rd, input logic br);
    rst = r; id_opcode = op; id_funct7 = f7; id_rs1 = rs1; id_rs2 = rs2;
    ex_MemRead = mr; ex_rd = rd; ex_BranchTaken = br;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    drive(1'b1, OP_I, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    advance();
  endtask

  task automatic test_reset();
    drive(1'b1, OP_R, 7'b0000001, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_STALL) begin
      errors++; $display("[TB] FAIL reset_hold: got %b expected %b", obs, E_STALL);
    end
    drive(1'b1, OP_I, 7'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== E_STALL) begin
      errors++; $display("[TB] FAIL reset_over_branch: got %b expected %b", obs, E_STALL);
    end
    advance();
    drive(1'b0, OP_I, 7'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin
      errors++; $display("[TB] FAIL reset_release: got %b expected %b", obs, E_NORM);
    end
    advance();
  endtask

  task automatic test_load_use();
    reset_pulse();
    drive(1'b0, OP_R, 7'd0, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_STALL) begin
      errors++; $display("[TB] FAIL load_use_rs1: got %b expected %b", obs, E_STALL);
    end
    advance();
    drive(1'b0, OP_R, 7'd0, 5'd5, 5'd7, 1'b0, 5'd9, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin
      errors++; $display("[TB] FAIL load_use_after: got %b expected %b", obs, E_NORM);
    end
    advance();
    drive(1'b0, OP_SW, 7'd0, 5'd7, 5'd5, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_STALL) begin
      errors++; $display("[TB] FAIL load_use_rs2: got %b expected %b", obs, E_STALL);
    end
    advance();
  endtask

  task automatic test_no_false_stall();
    reset_pulse();
    drive(1'b0, OP_R, 7'd0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin
      errors++; $display("[TB] FAIL x0_dest: got %b expected %b", obs, E_NORM);
    end
    advance();
    drive(1'b0, OP_I, 7'd0, 5'd9, 5'd5, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin
      errors++; $display("[TB] FAIL addi_rs2_unused: got %b expected %b", obs, E_NORM);
    end
    advance();
    drive(1'b0, OP_BAD, 7'd1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin
      errors++; $display("[TB] FAIL unknown_opcode: got %b expected %b", obs, E_NORM);
    end
    advance();
    drive(1'b0, OP_BR, 7'd0, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_STALL) begin
      errors++; $display("[TB] FAIL beq_rs2: got %b expected %b", obs, E_STALL);
    end
    advance();
    // mult with a load-use hazard stalls but stays out of MULTI
    drive(1'b0, OP_R, 7'b0000001, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_STALL) begin
      errors++; $display("[TB] FAIL mult_load_use: got %b expected %b", obs, E_STALL);
    end
    advance();
    drive(1'b0, OP_R, 7'b0000001, 5'd5, 5'd6, 1'b0, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== E_STALL) begin
      errors++; $display("[TB] FAIL mult_entry_after_lu: got %b expected %b", obs, E_STALL);
    end
    advance();
  endtask

  // Hazards on rs1 are presented during the count to show they are ignored.
  task automatic test_multi(input string name, input logic [6:0] f7, input int lat);
    int stalls;
    logic [4:0] exp;
    stalls = 0;
    reset_pulse();
    for (int c = 0; c <= lat; c++) begin
      if (c == 0)
        drive(1'b0, OP_R, f7, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0);
      else if (c < lat)
        drive(1'b0, OP_LW, 7'd0, 5'd4, 5'd3, 1'b1, 5'd4, 1'b0);
      else
        drive(1'b0, OP_I, 7'd0, 5'd1, 5'd1, 1'b0, 5'd0, 1'b0);
      if (c == 0) exp = E_STALL;
      else if (c < lat - 1) exp = E_STALL_BUSY;
      else if (c == lat - 1) exp = E_REL_BUSY;
      else exp = E_NORM;
      @(negedge clk);
      if (obs[4]) stalls++;
      checks++;
      if (obs !== exp) begin
        errors++; $display("[TB] FAIL %s_cycle%0d: got %b expected %b", name, c, obs, exp);
      end
      advance();
    end
    checks++;
    if (stalls !== lat - 1) begin
      errors++; $display("[TB] FAIL %s_stall_count: got %0d expected %0d", name, stalls, lat - 1);
    end
  endtask

  task automatic test_branch_during_multi();
    logic [4:0] exp;
    reset_pulse();
    for (int c = 0; c <= 5; c++) begin
      if (c < 4) begin
        drive(1'b0, OP_R, 7'b0000011, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0);
        exp = (c == 0) ? E_STALL : E_STALL_BUSY;
      end else if (c == 4) begin
        drive(1'b0, OP_R, 7'b0000011, 5'd2, 5'd3, 1'b0, 5'd0, 1'b1);
        exp = E_FLUSH_BUSY;
      end else begin
        drive(1'b0, OP_I, 7'd0, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0);
        exp = E_NORM;
      end
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++; $display("[TB] FAIL branch_multi_cycle%0d: got %b expected %b", c, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_branch_at_release();
    logic [4:0] exp;
    reset_pulse();
    for (int c = 0; c <= 3; c++) begin
      drive(1'b0, (c == 3) ? OP_I : OP_R, 7'b0000001, 5'd2, 5'd3, 1'b0, 5'd0, c == 2);
      case (c)
        0: exp = E_STALL;
        1: exp = E_STALL_BUSY;
        2: exp = E_FLUSH_BUSY;
        default: exp = E_NORM;
      endcase
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++; $display("[TB] FAIL branch_release_cycle%0d: got %b expected %b", c, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_multi();
    logic [4:0] exp;
    reset_pulse();
    for (int c = 0; c <= 6; c++) begin
      drive(c == 2, (c == 6) ? OP_I : OP_R, 7'b0000001, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0);
      case (c)
        0, 2, 3: exp = E_STALL;
        1, 4:    exp = E_STALL_BUSY;
        5:       exp = E_REL_BUSY;
        default: exp = E_NORM;
      endcase
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++; $display("[TB] FAIL reset_multi_cycle%0d: got %b expected %b", c, obs, exp);
      end
      advance();
    end
  endtask

  // Model tracks how many more stall cycles remain before the multi-op is released.
  task automatic test_random(input int n);
    logic [6:0] ops [6];
    logic [6:0] f7s [4];
    logic       m_busy;
    int         remaining;
    logic       r, mr, br, u1, u2, lu;
    logic [6:0] op, f7;
    logic [4:0] rs1, rs2, rd;
    int         lat;
    logic [4:0] exp;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BR; ops[5] = OP_BAD;
    f7s[0] = 7'd0; f7s[1] = 7'b0000001; f7s[2] = 7'b0000011; f7s[3] = 7'b0100000;
    m_busy = 1'b0;
    remaining = 0;
    for (int i = 0; i < n; i++) begin
      r   = (i == 0) || ($urandom_range(0, 49) == 0);
      br  = ($urandom_range(0, 9) == 0);
      op  = ($urandom_range(0, 2) == 0) ? OP_R : ops[$urandom_range(0, 5)];
      f7  = f7s[$urandom_range(0, 3)];
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      mr  = $urandom_range(0, 1) == 1;
      drive(r, op, f7, rs1, rs2, mr, rd, br);
      u1  = (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) || (op == OP_BR);
      u2  = (op == OP_R) || (op == OP_SW) || (op == OP_BR);
      lu  = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
      lat = (op == OP_R && f7 == 7'b0000001) ? MULT_LAT :
            (op == OP_R && f7 == 7'b0000011) ? MATR_LAT : 0;
      if (r) begin
        exp = E_STALL; m_busy = 1'b0; remaining = 0;
      end else if (br) begin
        exp = {4'b1111, m_busy}; m_busy = 1'b0;
      end else if (m_busy) begin
        if (remaining > 0) begin
          exp = E_STALL_BUSY; remaining--;
        end else begin
          exp = E_REL_BUSY; m_busy = 1'b0;
        end
      end else if (lu) begin
        exp = E_STALL;
      end else if (lat >= 2) begin
        exp = E_STALL; m_busy = 1'b1; remaining = lat - 2;
      end else begin
        exp = E_NORM;
      end
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++; $display("[TB] FAIL random_step%0d: got %b expected %b", i, obs, exp);
      end
      advance();
    end
  endtask

  initial begin
    drive(1'b1, OP_I, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    advance();
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_multi("mult", 7'b0000001, MULT_LAT);
    test_multi("matr", 7'b0000011, MATR_LAT);
    test_branch_during_multi();
    test_branch_at_release();
    test_reset_mid_multi();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
